// File: rtl/universal_cascade_counter.sv
// Multi-digit radix-MOD up/down counter: NCH cascaded N-bit digits, single-cycle ripple carry/borrow, wrap or saturate.
// Latency: 1 cycle from sampled controls to q; reset clears q/wrap_tick/ovf asynchronously.
// Backpressure: none; one step per enabled cycle, priority syn_clr > load > en.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   en, up, sat           count enable, direction (1=up), end mode (1=saturate, 0=wrap)
//   syn_clr, load, d      synchronous clear, parallel load of packed digits d
//   q                     registered packed digits, digit 0 at q[N-1:0]
//   max_tick, min_tick    all digits at MOD-1 / all digits at 0 (decoded from q)
//   wrap_tick             registered pulse, high for the cycle q shows a wrapped value
//   ovf                   sticky: terminal step attempted; cleared by syn_clr, load or reset
module universal_cascade_counter #(
    parameter int N   = 4,
    parameter int NCH = 4,
    parameter int MOD = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             syn_clr,
    input  logic             load,
    input  logic [NCH*N-1:0] d,
    output logic [NCH*N-1:0] q,
    output logic             max_tick,
    output logic             min_tick,
    output logic             wrap_tick,
    output logic             ovf
);

    // Top digit value, and the radix one bit wider so MOD = 2^N is representable.
    localparam logic [N-1:0] L_MAX = N'(MOD - 1);
    localparam logic [N:0]   L_MOD = (N + 1)'(MOD);

    logic [NCH*N-1:0] r_q;
    logic             r_wrap;
    logic             r_ovf;

    logic [NCH*N-1:0] w_step;
    logic [NCH*N-1:0] w_load;
    logic             w_all_max;
    logic             w_all_min;
    logic             w_term;

    // Per-digit carry/borrow ripple. At the terminal state the chain naturally
    // produces the wrapped value (all zeros going up, all MOD-1 going down),
    // so the sequential block only has to decide whether to accept it.
    always_comb begin
        logic         v_c;
        logic [N-1:0] v_dig;
        logic [N-1:0] v_ld;
        v_c       = 1'b1;
        v_dig     = '0;
        v_ld      = '0;
        w_step    = r_q;
        w_load    = '0;
        w_all_max = 1'b1;
        w_all_min = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            v_dig     = r_q[i*N +: N];
            w_all_max = w_all_max & (v_dig == L_MAX);
            w_all_min = w_all_min & (v_dig == '0);
            if (v_c) begin
                if (up) begin
                    if (v_dig == L_MAX) begin
                        w_step[i*N +: N] = '0;
                    end else begin
                        w_step[i*N +: N] = v_dig + N'(1);
                        v_c              = 1'b0;
                    end
                end else begin
                    if (v_dig == '0) begin
                        w_step[i*N +: N] = L_MAX;
                    end else begin
                        w_step[i*N +: N] = v_dig - N'(1);
                        v_c              = 1'b0;
                    end
                end
            end
            // Out-of-range load digits clamp to the top digit value.
            v_ld             = d[i*N +: N];
            w_load[i*N +: N] = ({1'b0, v_ld} >= L_MOD) ? L_MAX : v_ld;
        end
        w_term = en & (up ? w_all_max : w_all_min);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (syn_clr) begin
                r_q   <= '0;
                r_ovf <= 1'b0;
            end else if (load) begin
                r_q   <= w_load;
                r_ovf <= 1'b0;
            end else if (en) begin
                if (w_term) begin
                    r_ovf <= 1'b1;
                    if (!sat) begin
                        r_q    <= w_step;
                        r_wrap <= 1'b1;
                    end
                end else begin
                    r_q <= w_step;
                end
            end
        end
    end

    assign q         = r_q;
    assign max_tick  = w_all_max;
    assign min_tick  = w_all_min;
    assign wrap_tick = r_wrap;
    assign ovf       = r_ovf;

endmodule
